pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Each cycle it drives the `en`/`flush` pins of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It resolves data-memory waits, load-use hazards, EX-stage redirects and instruction-fetch misses, and sequences an orderly drain on `halt`. It also keeps saturating stall and flush performance counters.

---
 rtl/cpu_types_pkg.sv | 41 ++++
 rtl/pipeline_ctrl_if.sv | 48 ++++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices, pipeline-control state and latch-control bundle.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } pctrl_state_t;

  // Per-cycle latch control; a set flush bit loads a bubble whatever the en bit says.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pctrl_out_t;

  localparam pctrl_out_t CTRL_FREEZE   = 9'b0_0000_0000;
  localparam pctrl_out_t CTRL_RESET    = 9'b0_0000_1111;
  localparam pctrl_out_t CTRL_RUN      = 9'b1_1111_0000;
  localparam pctrl_out_t CTRL_REDIRECT = 9'b1_1111_1100;
  localparam pctrl_out_t CTRL_LOAD_USE = 9'b0_0111_0100;
  localparam pctrl_out_t CTRL_IMISS    = 9'b0_1111_1000;
  localparam pctrl_out_t CTRL_DRAIN    = 9'b0_1111_1110;

  // A load in EX feeding either source of the instruction in ID; r0 never forwards.
  function automatic logic load_use_hazard(input logic     ex_load,
                                           input regbits_t ex_rt,
                                           input regbits_t id_rs,
                                           input regbits_t id_rt);
    return ex_load && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of the pipeline-control signals with a controller-side and a driver-side view.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
) (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic             RST;
  logic             ihit;
  logic             dhit;
  regbits_t         id_rs;
  regbits_t         id_rt;
  logic             ex_dREN;
  regbits_t         ex_rt;
  logic             ex_redirect;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_halt;
  logic             wb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport pc (
    input  CLK, RST, ihit, dhit, id_rs, id_rt, ex_dREN, ex_rt, ex_redirect,
           mem_dREN, mem_dWEN, mem_halt, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, stall_cnt, flush_cnt
  );

  modport tb (
    input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, stall_cnt, flush_cnt,
    output RST, ihit, dhit, id_rs, id_rt, ex_dREN, ex_rt, ex_redirect,
           mem_dREN, mem_dWEN, mem_halt, wb_halt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline, with halt drain and perf counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             ex_dREN,
  input  regbits_t         ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t state_q;
  pctrl_out_t   ctrl;
  logic         dwait;
  logic         load_use;
  logic         stall_inc;
  logic         flush_inc;

  // Hazard priority resolution; outputs act on the same edge as the hazard.
  always_comb begin
    dwait     = (mem_dREN || mem_dWEN) && !dhit;
    load_use  = load_use_hazard(ex_dREN, ex_rt, id_rs, id_rt);
    ctrl      = CTRL_FREEZE;
    flush_inc = 1'b0;
    if (RST) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          if (dwait) begin
            ctrl = CTRL_FREEZE;
          end else if (mem_halt) begin
            // Halt reached MEM: kill everything younger, let only the halt retire.
            ctrl = CTRL_DRAIN;
          end else if (ex_redirect) begin
            ctrl      = CTRL_REDIRECT;
            flush_inc = 1'b1;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end else if (!ihit) begin
            ctrl = CTRL_IMISS;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        DRAIN:   ctrl = dwait ? CTRL_FREEZE : CTRL_DRAIN;
        HALTED:  ctrl = CTRL_FREEZE;
        default: ctrl = CTRL_FREEZE;
      endcase
    end
    stall_inc = (state_q == RUN) && !ctrl.pc_en;
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;

  // State sequencing and the registered halt flag (rises the cycle after HALTED is entered).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt    <= 1'b0;
    end else begin
      unique case (state_q)
        RUN:     if (mem_halt && !dwait) state_q <= DRAIN;
        DRAIN:   if (wb_halt) state_q <= HALTED;
        HALTED:  halt <= 1'b1;
        default: state_q <= RUN;
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .clr   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .CLK   (CLK),
    .clr   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner sequences, random run.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_dREN;
    logic [4:0] ex_rt;
    logic       ex_redirect;
    logic       mem_dREN;
    logic       mem_dWEN;
    logic       mem_halt;
    logic       wb_halt;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  // Expected control words: {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
  localparam logic [8:0] E_RUN   = 9'b1_1111_0000;
  localparam logic [8:0] E_FRZ   = 9'b0_0000_0000;
  localparam logic [8:0] E_RST   = 9'b0_0000_1111;
  localparam logic [8:0] E_REDIR = 9'b1_1111_1100;
  localparam logic [8:0] E_LU    = 9'b0_0111_0100;
  localparam logic [8:0] E_IMISS = 9'b0_1111_1000;
  localparam logic [8:0] E_DRAIN = 9'b0_1111_1110;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_ctrl_if #(.CNT_W(32)) bus (.CLK(CLK));

  logic       pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
  logic       ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, halt4;
  logic [3:0] stall_cnt4, flush_cnt4;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .CLK         (CLK),
    .RST         (bus.RST),
    .ihit        (bus.ihit),
    .dhit        (bus.dhit),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .ex_dREN     (bus.ex_dREN),
    .ex_rt       (bus.ex_rt),
    .ex_redirect (bus.ex_redirect),
    .mem_dREN    (bus.mem_dREN),
    .mem_dWEN    (bus.mem_dWEN),
    .mem_halt    (bus.mem_halt),
    .wb_halt     (bus.wb_halt),
    .pc_en       (bus.pc_en),
    .ifid_en     (bus.ifid_en),
    .idex_en     (bus.idex_en),
    .exmem_en    (bus.exmem_en),
    .memwb_en    (bus.memwb_en),
    .ifid_flush  (bus.ifid_flush),
    .idex_flush  (bus.idex_flush),
    .exmem_flush (bus.exmem_flush),
    .memwb_flush (bus.memwb_flush),
    .halt        (bus.halt),
    .stall_cnt   (bus.stall_cnt),
    .flush_cnt   (bus.flush_cnt)
  );

  // Narrow-counter copy sharing the same inputs, for the saturation check.
  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK         (CLK),
    .RST         (bus.RST),
    .ihit        (bus.ihit),
    .dhit        (bus.dhit),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .ex_dREN     (bus.ex_dREN),
    .ex_rt       (bus.ex_rt),
    .ex_redirect (bus.ex_redirect),
    .mem_dREN    (bus.mem_dREN),
    .mem_dWEN    (bus.mem_dWEN),
    .mem_halt    (bus.mem_halt),
    .wb_halt     (bus.wb_halt),
    .pc_en       (pc_en4),
    .ifid_en     (ifid_en4),
    .idex_en     (idex_en4),
    .exmem_en    (exmem_en4),
    .memwb_en    (memwb_en4),
    .ifid_flush  (ifid_flush4),
    .idex_flush  (idex_flush4),
    .exmem_flush (exmem_flush4),
    .memwb_flush (memwb_flush4),
    .halt        (halt4),
    .stall_cnt   (stall_cnt4),
    .flush_cnt   (flush_cnt4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic in_t nop();
    in_t v;
    v      = '0;
    v.ihit = 1'b1;
    v.dhit = 1'b1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    bus.ihit        = v.ihit;
    bus.dhit        = v.dhit;
    bus.id_rs       = v.id_rs;
    bus.id_rt       = v.id_rt;
    bus.ex_dREN     = v.ex_dREN;
    bus.ex_rt       = v.ex_rt;
    bus.ex_redirect = v.ex_redirect;
    bus.mem_dREN    = v.mem_dREN;
    bus.mem_dWEN    = v.mem_dWEN;
    bus.mem_halt    = v.mem_halt;
    bus.wb_halt     = v.wb_halt;
  endtask

  function automatic logic [8:0] act_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
  endfunction

  // Reference: what the pipe must do this cycle while running, from the hazard rules.
  function automatic logic [8:0] model_run(input in_t v);
    logic pc, e1, e2, e3, e4, f1, f2, f3, f4;
    logic mem_wait, lu;
    pc = 1; e1 = 1; e2 = 1; e3 = 1; e4 = 1; f1 = 0; f2 = 0; f3 = 0; f4 = 0;
    mem_wait = (v.mem_dREN | v.mem_dWEN) & ~v.dhit;
    lu = v.ex_dREN && (v.ex_rt != 0) && ((v.ex_rt == v.id_rs) || (v.ex_rt == v.id_rt));
    if (mem_wait) begin
      pc = 0; e1 = 0; e2 = 0; e3 = 0; e4 = 0;
    end else if (v.ex_redirect) begin
      f1 = 1; f2 = 1;
    end else if (lu) begin
      pc = 0; e1 = 0; f2 = 1;
    end else if (!v.ihit) begin
      pc = 0; f1 = 1;
    end
    return {pc, e1, e2, e3, e4, f1, f2, f3, f4};
  endfunction

  task automatic cyc(input string name, input in_t v, input logic [8:0] exp);
    @(negedge CLK);
    drive(v);
    #1;
    chk(name, 64'(act_ctrl()), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    bus.RST = 1'b1;
    drive(nop());
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_ctrl", 64'(act_ctrl()), 64'(E_RST));
    chk("reset_halt", 64'(bus.halt), 64'd0);
    chk("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("reset_flush_cnt", 64'(bus.flush_cnt), 64'd0);
    bus.RST = 1'b0;
  endtask

  vec_t tbl[$];

  task automatic add_vec(input string name, input logic ih, input logic dh, input int rs,
                         input int rt, input logic ld, input int ert, input logic rd,
                         input logic mr, input logic mw, input logic [8:0] exp);
    vec_t e;
    e.name           = name;
    e.in             = '0;
    e.in.ihit        = ih;
    e.in.dhit        = dh;
    e.in.id_rs       = 5'(rs);
    e.in.id_rt       = 5'(rt);
    e.in.ex_dREN     = ld;
    e.in.ex_rt       = 5'(ert);
    e.in.ex_redirect = rd;
    e.in.mem_dREN    = mr;
    e.in.mem_dWEN    = mw;
    e.exp            = exp;
    tbl.push_back(e);
  endtask

  initial begin
    in_t v;
    logic [8:0] e;
    int exp_stall, exp_flush;
    bus.RST = 1'b1;
    drive(nop());

    //           name            ih dh rs rt ld ert rd mr mw  expected
    add_vec("nop",               1, 1, 1, 2, 0, 0,  0, 0, 0, E_RUN);
    add_vec("lu_rs",             1, 1, 5, 2, 1, 5,  0, 0, 0, E_LU);
    add_vec("lu_rt",             1, 1, 3, 7, 1, 7,  0, 0, 0, E_LU);
    add_vec("lu_r0",             1, 1, 0, 0, 1, 0,  0, 0, 0, E_RUN);
    add_vec("load_nomatch",      1, 1, 3, 4, 1, 5,  0, 0, 0, E_RUN);
    add_vec("nonload_match",     1, 1, 5, 5, 0, 5,  0, 0, 0, E_RUN);
    add_vec("imiss",             0, 1, 1, 2, 0, 0,  0, 0, 0, E_IMISS);
    add_vec("redir_imiss",       0, 1, 1, 2, 0, 0,  1, 0, 0, E_REDIR);
    add_vec("redir_lu",          1, 1, 5, 2, 1, 5,  1, 0, 0, E_REDIR);
    add_vec("dwait_rd",          1, 0, 1, 2, 0, 0,  0, 1, 0, E_FRZ);
    add_vec("dwait_wr",          1, 0, 1, 2, 0, 0,  0, 0, 1, E_FRZ);
    add_vec("dmem_hit",          1, 1, 1, 2, 0, 0,  0, 1, 0, E_RUN);
    add_vec("dwait_redir",       1, 0, 1, 2, 0, 0,  1, 1, 0, E_FRZ);
    add_vec("lu_imiss",          0, 1, 6, 2, 1, 6,  0, 0, 0, E_LU);
    add_vec("dwait_lu_imiss",    0, 0, 6, 2, 1, 6,  0, 0, 1, E_FRZ);

    do_reset();
    foreach (tbl[i]) cyc(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Load-use inserts exactly one bubble: the load has moved on in the next cycle.
    do_reset();
    v = nop(); v.ex_dREN = 1; v.ex_rt = 5'd5; v.id_rs = 5'd5;
    cyc("lu_seq_stall", v, E_LU);
    cyc("lu_seq_resume", nop(), E_RUN);
    @(negedge CLK); #1;
    chk("lu_seq_stall_cnt", 64'(bus.stall_cnt), 64'd1);

    // Three dwait freezes with a pending redirect, then the redirect fires on dhit.
    do_reset();
    v = nop(); v.mem_dREN = 1; v.dhit = 0; v.ex_redirect = 1;
    for (int i = 0; i < 3; i++) cyc("dwait_redir_freeze", v, E_FRZ);
    v.dhit = 1;
    cyc("dwait_redir_fire", v, E_REDIR);
    cyc("dwait_redir_after", nop(), E_RUN);
    chk("dwait_redir_stall_cnt", 64'(bus.stall_cnt), 64'd3);
    chk("dwait_redir_flush_cnt", 64'(bus.flush_cnt), 64'd1);

    // Halt drain with a data wait inside DRAIN, then HALTED and the registered halt flag.
    do_reset();
    v = nop(); v.mem_halt = 1;
    cyc("drain_enter", v, E_DRAIN);
    v = nop(); v.mem_dREN = 1; v.dhit = 0;
    cyc("drain_dwait", v, E_FRZ);
    v = nop(); v.wb_halt = 1;
    cyc("drain_wb", v, E_DRAIN);
    cyc("halted_first", nop(), E_FRZ);
    chk("halt_first_cycle", 64'(bus.halt), 64'd0);
    for (int i = 0; i < 11; i++) begin
      v = nop(); v.ex_redirect = 1; v.ihit = 0;
      cyc("halted_hold", v, E_FRZ);
      chk("halt_high", 64'(bus.halt), 64'd1);
    end
    chk("halted_flush_cnt", 64'(bus.flush_cnt), 64'd0);
    do_reset();
    cyc("after_halt_run", nop(), E_RUN);

    // Reset while draining returns straight to RUN.
    v = nop(); v.mem_halt = 1;
    cyc("drain_enter2", v, E_DRAIN);
    do_reset();
    cyc("after_drain_rst_run", nop(), E_RUN);

    // Saturation: 20 fetch-miss stalls on the 4-bit instance.
    do_reset();
    v = nop(); v.ihit = 0;
    for (int i = 0; i < 20; i++) cyc("sat_imiss", v, E_IMISS);
    cyc("sat_after", nop(), E_RUN);
    chk("sat_stall_cnt4", 64'(stall_cnt4), 64'd15);
    chk("sat_stall_cnt32", 64'(bus.stall_cnt), 64'd20);
    chk("sat_flush_cnt4", 64'(flush_cnt4), 64'd0);

    // Random hazard mix against the reference rules and integer counter tallies.
    do_reset();
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 400; i++) begin
      v             = '0;
      v.ihit        = ($urandom_range(0, 9) < 8);
      v.dhit        = ($urandom_range(0, 9) < 6);
      v.id_rs       = 5'($urandom_range(0, 3));
      v.id_rt       = 5'($urandom_range(0, 3));
      v.ex_dREN     = ($urandom_range(0, 9) < 4);
      v.ex_rt       = 5'($urandom_range(0, 3));
      v.ex_redirect = ($urandom_range(0, 9) < 2);
      v.mem_dREN    = ($urandom_range(0, 9) < 2);
      v.mem_dWEN    = ($urandom_range(0, 9) < 1);
      e = model_run(v);
      @(negedge CLK);
      drive(v);
      #1;
      chk("rand_ctrl", 64'(act_ctrl()), 64'(e));
      chk("rand_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));
      chk("rand_flush_cnt", 64'(bus.flush_cnt), 64'(exp_flush));
      if (!e[8]) exp_stall++;
      if (v.ex_redirect && !((v.mem_dREN || v.mem_dWEN) && !v.dhit)) exp_flush++;
    end
    @(negedge CLK);
    drive(nop());
    #1;
    chk("rand_final_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));
    chk("rand_final_flush_cnt", 64'(bus.flush_cnt), 64'(exp_flush));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
